// File: rtl/r5_pkg.sv
// Shared types and constants for the radix-5 FFT datapath.
package r5_pkg;

  localparam int R5_RADIX = 5;
  localparam int R5_W     = 32;

  typedef logic [2:0] r5_slot_t;

  typedef struct packed {
    logic [R5_W-1:0] re;
    logic [R5_W-1:0] img;
  } r5_cplx_t;

endpackage

// File: rtl/r5_slot_ctr.sv
// Mod-5 slot counter with enable, synchronous clear and load-to-1 for frame resync.
module r5_slot_ctr
  import r5_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     en,
  input  logic     load1,
  output r5_slot_t slot,
  output logic     last
);

  r5_slot_t slot_q, slot_d;

  assign last = (slot_q == r5_slot_t'(R5_RADIX - 1));
  assign slot = slot_q;

  // A resync sample occupies slot 0 itself, so the next sample goes to slot 1.
  always_comb begin
    slot_d = slot_q;
    if (load1) begin
      slot_d = r5_slot_t'(1);
    end else if (en) begin
      slot_d = last ? r5_slot_t'(0) : slot_q + r5_slot_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

endmodule

// File: rtl/r5_input_collector.sv
// Gathers five consecutive complex samples into a parallel group with a one-cycle out_valid strobe.
// Optional R5_SOF_RESYNC_EN: in_sof realigns grouping to slot 0 and flags discarded partial groups.
module r5_input_collector
  import r5_pkg::*;
#(
  parameter int W = R5_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic         in_sof,
  input  logic [W-1:0] a_re,
  input  logic [W-1:0] a_img,
  output logic [W-1:0] x0_re,
  output logic [W-1:0] x0_img,
  output logic [W-1:0] x1_re,
  output logic [W-1:0] x1_img,
  output logic [W-1:0] x2_re,
  output logic [W-1:0] x2_img,
  output logic [W-1:0] x3_re,
  output logic [W-1:0] x3_img,
  output logic [W-1:0] x4_re,
  output logic [W-1:0] x4_img,
  output logic         out_valid,
  output logic         sof_err
);

  typedef struct packed {
    logic [W-1:0] re;
    logic [W-1:0] img;
  } lane_t;

  lane_t    stg_q  [R5_RADIX-1];
  lane_t    stg_d  [R5_RADIX-1];
  lane_t    lane_q [R5_RADIX];
  lane_t    lane_d [R5_RADIX];
  logic     out_valid_q, out_valid_d;
  logic     sof_err_q, sof_err_d;
  lane_t    sample;
  r5_slot_t slot;
  logic     last;
  logic     resync;

`ifdef R5_SOF_RESYNC_EN
  assign resync = in_valid & in_sof;
`else
  logic sof_unused;
  assign sof_unused = in_sof;
  assign resync     = 1'b0;
`endif

  r5_slot_ctr u_slot_ctr (
    .clk   (clk),
    .rst   (rst),
    .en    (in_valid),
    .load1 (resync),
    .slot  (slot),
    .last  (last)
  );

  assign sample = '{re: a_re, img: a_img};

  // The fifth sample bypasses staging and lands straight in lane 4.
  always_comb begin
    stg_d       = stg_q;
    lane_d      = lane_q;
    out_valid_d = 1'b0;
    sof_err_d   = 1'b0;
    if (resync) begin
      stg_d[0]  = sample;
      sof_err_d = (slot != r5_slot_t'(0));
    end else if (in_valid && last) begin
      for (int i = 0; i < R5_RADIX - 1; i++) begin
        lane_d[i] = stg_q[i];
      end
      lane_d[R5_RADIX-1] = sample;
      out_valid_d        = 1'b1;
    end else if (in_valid) begin
      for (int i = 0; i < R5_RADIX - 1; i++) begin
        if (slot == r5_slot_t'(i)) begin
          stg_d[i] = sample;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stg_q       <= '{default: '0};
      lane_q      <= '{default: '0};
      out_valid_q <= 1'b0;
      sof_err_q   <= 1'b0;
    end else begin
      stg_q       <= stg_d;
      lane_q      <= lane_d;
      out_valid_q <= out_valid_d;
      sof_err_q   <= sof_err_d;
    end
  end

  assign x0_re     = lane_q[0].re;
  assign x0_img    = lane_q[0].img;
  assign x1_re     = lane_q[1].re;
  assign x1_img    = lane_q[1].img;
  assign x2_re     = lane_q[2].re;
  assign x2_img    = lane_q[2].img;
  assign x3_re     = lane_q[3].re;
  assign x3_img    = lane_q[3].img;
  assign x4_re     = lane_q[4].re;
  assign x4_img    = lane_q[4].img;
  assign out_valid = out_valid_q;
  assign sof_err   = sof_err_q;

endmodule

// File: tb/tb_r5_input_collector.sv
// Scoreboard bench for r5_input_collector; expected groups are queued as stimulus is driven.
module tb_r5_input_collector;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_sof;
  logic [W-1:0] a_re, a_img;
  logic [W-1:0] x0_re, x0_img, x1_re, x1_img, x2_re, x2_img;
  logic [W-1:0] x3_re, x3_img, x4_re, x4_img;
  logic         out_valid, sof_err;

  typedef struct packed {
    logic [4:0][W-1:0] re;
    logic [4:0][W-1:0] img;
  } grp_t;

  grp_t              exp_q[$];
  grp_t              exp_g;
  int                pulse_cyc[$];
  int                n_cmp = 0;
  int                n_err = 0;
  int                n_pulse = 0;
  int                n_sof_err = 0;
  int                cyc = 0;
  logic              rst_s = 1'b1;
  logic [4:0][W-1:0] got_re, got_img, prev_re, prev_img;

  r5_input_collector #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .a_re      (a_re),
    .a_img     (a_img),
    .x0_re     (x0_re),
    .x0_img    (x0_img),
    .x1_re     (x1_re),
    .x1_img    (x1_img),
    .x2_re     (x2_re),
    .x2_img    (x2_img),
    .x3_re     (x3_re),
    .x3_img    (x3_img),
    .x4_re     (x4_re),
    .x4_img    (x4_img),
    .out_valid (out_valid),
    .sof_err   (sof_err)
  );

  always #5 clk = ~clk;

  assign got_re  = {x4_re, x3_re, x2_re, x1_re, x0_re};
  assign got_img = {x4_img, x3_img, x2_img, x1_img, x0_img};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one input cycle; returns 1 time unit after the edge that samples it.
  task automatic drv(input logic v, input logic s, input logic [W-1:0] re, input logic [W-1:0] im);
    in_valid = v;
    in_sof   = s;
    a_re     = re;
    a_img    = im;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drv(1'b0, 1'b0, '0, '0);
  endtask

  function automatic grp_t mk_neg(input int base);
    grp_t g;
    for (int i = 0; i < 5; i++) begin
      g.re[i]  = W'(base + i);
      g.img[i] = W'(-(base + i));
    end
    return g;
  endfunction

  always @(posedge clk) rst_s <= rst;

  always @(negedge clk) begin
    cyc++;
    if (rst_s) begin
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_sof_err", 64'(sof_err), 64'd0);
      check("rst_lanes_zero", 64'(|{got_re, got_img}), 64'd0);
      prev_re  = '0;
      prev_img = '0;
    end else if (out_valid) begin
      n_pulse++;
      pulse_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 64'd1, 64'd0);
      end else begin
        exp_g = exp_q.pop_front();
        for (int i = 0; i < 5; i++) begin
          check($sformatf("x%0d_re", i), 64'(got_re[i]), 64'(exp_g.re[i]));
          check($sformatf("x%0d_img", i), 64'(got_img[i]), 64'(exp_g.img[i]));
        end
      end
      prev_re  = got_re;
      prev_img = got_img;
    end else begin
      check("lane_hold", 64'({got_re, got_img} == {prev_re, prev_img}), 64'd1);
    end
    if (sof_err) n_sof_err++;
  end

  initial begin
    grp_t g;
    int   p0;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    a_re     = '0;
    a_img    = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_lanes", 64'(|{got_re, got_img}), 64'd0);

    // Basic group with latency check.
    exp_q.push_back(mk_neg(1));
    for (int i = 0; i < 5; i++) begin
      drv(1'b1, 1'b0, W'(i + 1), W'(-(i + 1)));
      if (i == 3) check("latency_not_early", 64'(out_valid), 64'd0);
    end
    check("latency_out_valid", 64'(out_valid), 64'd1);
    idle(3);

    // 20 back-to-back samples: four groups, five cycles apart.
    pulse_cyc.delete();
    for (int v = 0; v < 20; v++) begin
      g.re[v % 5]  = W'(v);
      g.img[v % 5] = ~W'(v);
      if (v % 5 == 4) exp_q.push_back(g);
    end
    for (int v = 0; v < 20; v++) drv(1'b1, 1'b0, W'(v), ~W'(v));
    idle(2);
    check("b2b_pulses", 64'(pulse_cyc.size()), 64'd4);
    for (int k = 1; k < 4; k++) begin
      if (k < pulse_cyc.size()) check("b2b_gap", 64'(pulse_cyc[k] - pulse_cyc[k-1]), 64'd5);
    end

    // Gap inside a group.
    p0 = n_pulse;
    exp_q.push_back(mk_neg(1));
    drv(1'b1, 1'b0, W'(1), W'(-1));
    drv(1'b1, 1'b0, W'(2), W'(-2));
    idle(3);
    drv(1'b1, 1'b0, W'(3), W'(-3));
    drv(1'b1, 1'b0, W'(4), W'(-4));
    drv(1'b1, 1'b0, W'(5), W'(-5));
    check("gap_latency", 64'(out_valid), 64'd1);
    idle(3);
    check("gap_pulses", 64'(n_pulse - p0), 64'd1);

    // Start-of-frame in the middle of a group.
`ifdef R5_SOF_RESYNC_EN
    exp_q.push_back(mk_neg(7));
`else
    g = mk_neg(1);
    g.re[3]  = W'(7);
    g.img[3] = W'(-7);
    g.re[4]  = W'(8);
    g.img[4] = W'(-8);
    exp_q.push_back(g);
`endif
    drv(1'b1, 1'b0, W'(1), W'(-1));
    drv(1'b1, 1'b0, W'(2), W'(-2));
    drv(1'b1, 1'b0, W'(3), W'(-3));
    drv(1'b1, 1'b1, W'(7), W'(-7));
    for (int v = 8; v <= 11; v++) drv(1'b1, 1'b0, W'(v), W'(-v));
    idle(2);
`ifdef R5_SOF_RESYNC_EN
    check("sof_err_count", 64'(n_sof_err), 64'd1);
`else
    check("sof_err_count", 64'(n_sof_err), 64'd0);
`endif
    rst = 1'b1;
    drv(1'b1, 1'b0, W'(77), W'(77));
    rst = 1'b0;
    idle(1);

    // Reset in the middle of a group; in_valid during reset is ignored.
    exp_q.push_back(mk_neg(10));
    for (int v = 21; v <= 23; v++) drv(1'b1, 1'b0, W'(v), W'(-v));
    rst = 1'b1;
    drv(1'b1, 1'b0, W'(50), W'(50));
    check("midgroup_reset_lanes", 64'(|{got_re, got_img}), 64'd0);
    rst = 1'b0;
    for (int v = 10; v <= 14; v++) drv(1'b1, 1'b0, W'(v), W'(-v));
    idle(2);

    // Extreme values, bit-exact; sof at slot 0 is not an error.
    g.re  = {32'h7FFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h80000000, 32'h7FFFFFFF};
    g.img = {32'h80000000, 32'h7FFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h80000000};
    exp_q.push_back(g);
    for (int i = 0; i < 5; i++) drv(1'b1, (i == 0), g.re[i], g.img[i]);
    g.re  = {32'h00000000, 32'h7FFFFFFF, 32'h00000001, 32'hFFFFFFFF, 32'h80000000};
    g.img = {32'hFFFFFFFF, 32'h00000001, 32'h80000000, 32'h00000000, 32'h7FFFFFFF};
    exp_q.push_back(g);
    for (int i = 0; i < 5; i++) drv(1'b1, 1'b0, g.re[i], g.img[i]);
    idle(3);

`ifdef R5_SOF_RESYNC_EN
    check("sof_err_final", 64'(n_sof_err), 64'd1);
`else
    check("sof_err_final", 64'(n_sof_err), 64'd0);
`endif
    check("total_pulses", 64'(n_pulse), 64'd10);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
